// File: rtl/qci_ingress_frame_buffer_pkg.sv
// qci_pkg: shared types and helpers for the Qci ingress frame buffer.
//   FRAME_LEN_W   - width of committed frame lengths (bytes)
//   write_state_t - ingress side: accepting beats, or discarding an oversize tail
//   read_state_t  - egress side: idle, first beat presented, streaming
//   popcount8     - number of set bits in an 8-bit tkeep
package qci_pkg;

  localparam int FRAME_LEN_W = 11;

  typedef enum logic {
    W_ACCEPT,
    W_DROP
  } write_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_LOAD,
    R_SEND
  } read_state_t;

  function automatic logic [3:0] popcount8(input logic [7:0] keep);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      n = n + {3'b000, keep[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/qci_ingress_frame_buffer_if.sv
// qci_ingress_frame_buffer_if: 64-bit AXI-Stream bundle.
//   tdata/tkeep/tlast/tvalid driven by the master, tready driven by the slave.
//   master - the side producing the stream
//   slave  - the side consuming the stream
interface qci_ingress_frame_buffer_if;

  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);

endinterface

// File: rtl/qci_ingress_frame_buffer_sdp_ram.sv
// qci_sdp_ram: simple dual-port RAM, one write port and one read port with
// a registered, enable-gated read. The read register holds its value while
// re is low and clears on reset.
//   clk, rst      - clock, asynchronous active-high reset (read register only)
//   we/waddr/wdata - write port
//   re/raddr/rdata - read port, rdata valid the cycle after re
module qci_sdp_ram #(
  parameter int AW = 9,
  parameter int W  = 73
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [1 << AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/qci_ingress_frame_buffer.sv
// qci_ingress_frame_buffer: store-and-forward buffer ahead of the Qci
// filtering/policing pipeline. Beats are written speculatively and become
// visible to the egress side only when the frame's tlast commits; frames
// longer than MAX_LEN bytes are rolled back and counted.
//   clk, rst        - clock, asynchronous active-high reset
//   rx_axis         - ingress AXI-Stream (slave)
//   tx_axis         - egress AXI-Stream (master)
//   frame_len_out   - byte length of the frame on tx, stable for the whole frame
//   drop_count_out  - oversize frames dropped, saturating at 0xFFFF
module qci_ingress_frame_buffer
  import qci_pkg::*;
#(
  parameter int DATA_AW = 9,
  parameter int LEN_AW  = 4,
  parameter int MAX_LEN = 1522
) (
  input  logic                         clk,
  input  logic                         rst,
  qci_ingress_frame_buffer_if.slave    rx_axis,
  qci_ingress_frame_buffer_if.master   tx_axis,
  output logic [FRAME_LEN_W-1:0]       frame_len_out,
  output logic [15:0]                  drop_count_out
);

  localparam int DATA_DEPTH = 1 << DATA_AW;
  localparam int LEN_DEPTH  = 1 << LEN_AW;
  localparam int RAM_W      = 64 + 8 + 1;

  localparam logic [DATA_AW:0] DATA_FULL_LVL = {1'b1, {DATA_AW{1'b0}}};
  localparam logic [LEN_AW:0]  LEN_FULL_LVL  = {1'b1, {LEN_AW{1'b0}}};

  if (MAX_LEN > 2047 || MAX_LEN < 1 || DATA_DEPTH < (MAX_LEN + 7) / 8 + 1) begin : g_bad_params
    $error("qci_ingress_frame_buffer: MAX_LEN must be 1..2047 and fit in 2^DATA_AW - 1 beats");
  end

  // Pointers carry one extra bit so full/empty fall out of plain subtraction.
  logic [DATA_AW:0]      wr_spec, wr_spec_nxt;
  logic [DATA_AW:0]      wr_commit, wr_commit_nxt;
  logic [DATA_AW:0]      rd_ptr, rd_ptr_nxt;
  logic [LEN_AW:0]       len_wr, len_rd, len_cnt;
  logic [FRAME_LEN_W-1:0] len_mem [LEN_DEPTH];

  logic [11:0]           byte_cnt, byte_cnt_nxt, beat_sum;
  write_state_t          wr_state, wr_state_nxt;
  read_state_t           rd_state, rd_state_nxt;
  logic [FRAME_LEN_W-1:0] frame_len_nxt;

  logic data_full, len_full, len_empty, oversize, rd_busy, tx_beat;
  logic ram_we, ram_re, len_push, len_pop, drop_inc;
  logic [RAM_W-1:0] ram_rdata;

  assign beat_sum  = byte_cnt + 12'(popcount8(rx_axis.tkeep));
  assign oversize  = beat_sum > 12'(MAX_LEN);
  assign data_full = (wr_spec - rd_ptr) == DATA_FULL_LVL;
  assign len_cnt   = len_wr - len_rd;
  assign len_empty = len_cnt == '0;
  assign rd_busy   = rd_state != R_IDLE;
  // The frame already popped onto tx still occupies a slot, so at most
  // LEN_DEPTH frames are resident in total.
  assign len_full  = (len_cnt == LEN_FULL_LVL) ||
                     ((len_cnt == LEN_FULL_LVL - 1'b1) && rd_busy);

  // ---------------------------------------------------------------- write
  always_comb begin
    wr_state_nxt   = wr_state;
    wr_spec_nxt    = wr_spec;
    wr_commit_nxt  = wr_commit;
    byte_cnt_nxt   = byte_cnt;
    ram_we         = 1'b0;
    len_push       = 1'b0;
    drop_inc       = 1'b0;
    rx_axis.tready = 1'b0;
    unique case (wr_state)
      W_ACCEPT: begin
        rx_axis.tready = !data_full && !len_full;
        if (rx_axis.tvalid && !data_full && !len_full) begin
          if (oversize) begin
            wr_spec_nxt  = wr_commit;
            drop_inc     = 1'b1;
            byte_cnt_nxt = '0;
            if (!rx_axis.tlast) begin
              wr_state_nxt = W_DROP;
            end
          end else begin
            ram_we      = 1'b1;
            wr_spec_nxt = wr_spec + 1'b1;
            if (rx_axis.tlast) begin
              wr_commit_nxt = wr_spec + 1'b1;
              len_push      = 1'b1;
              byte_cnt_nxt  = '0;
            end else begin
              byte_cnt_nxt = beat_sum;
            end
          end
        end
      end
      W_DROP: begin
        rx_axis.tready = 1'b1;
        if (rx_axis.tvalid && rx_axis.tlast) begin
          wr_state_nxt = W_ACCEPT;
          byte_cnt_nxt = '0;
        end
      end
      default: wr_state_nxt = W_ACCEPT;
    endcase
    if (rst) begin
      rx_axis.tready = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state       <= W_ACCEPT;
      wr_spec        <= '0;
      wr_commit      <= '0;
      byte_cnt       <= '0;
      len_wr         <= '0;
      drop_count_out <= '0;
    end else begin
      wr_state  <= wr_state_nxt;
      wr_spec   <= wr_spec_nxt;
      wr_commit <= wr_commit_nxt;
      byte_cnt  <= byte_cnt_nxt;
      if (len_push) begin
        len_wr <= len_wr + 1'b1;
      end
      if (drop_inc && drop_count_out != 16'hFFFF) begin
        drop_count_out <= drop_count_out + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (len_push) begin
      len_mem[len_wr[LEN_AW-1:0]] <= beat_sum[FRAME_LEN_W-1:0];
    end
  end

  // ---------------------------------------------------------------- read
  // The RAM read register doubles as the tx output register: it only loads
  // when a new beat is wanted, so it holds across stalls and streams one
  // beat per cycle. At a tlast handshake the next frame's first beat is
  // fetched in the same cycle when its length is already queued.
  always_comb begin
    rd_state_nxt   = rd_state;
    rd_ptr_nxt     = rd_ptr;
    frame_len_nxt  = frame_len_out;
    ram_re         = 1'b0;
    len_pop        = 1'b0;
    tx_axis.tvalid = rd_busy;
    tx_beat        = rd_busy && tx_axis.tready;
    unique case (rd_state)
      R_IDLE: begin
        if (!len_empty) begin
          len_pop      = 1'b1;
          ram_re       = 1'b1;
          rd_state_nxt = R_LOAD;
        end
      end
      R_LOAD, R_SEND: begin
        rd_state_nxt = R_SEND;
        if (tx_beat) begin
          if (!tx_axis.tlast) begin
            ram_re = 1'b1;
          end else if (!len_empty) begin
            len_pop      = 1'b1;
            ram_re       = 1'b1;
            rd_state_nxt = R_LOAD;
          end else begin
            rd_state_nxt = R_IDLE;
          end
        end
      end
      default: rd_state_nxt = R_IDLE;
    endcase
    if (ram_re) begin
      rd_ptr_nxt = rd_ptr + 1'b1;
    end
    if (len_pop) begin
      frame_len_nxt = len_mem[len_rd[LEN_AW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state      <= R_IDLE;
      rd_ptr        <= '0;
      len_rd        <= '0;
      frame_len_out <= '0;
    end else begin
      rd_state      <= rd_state_nxt;
      rd_ptr        <= rd_ptr_nxt;
      frame_len_out <= frame_len_nxt;
      if (len_pop) begin
        len_rd <= len_rd + 1'b1;
      end
    end
  end

  qci_sdp_ram #(
    .AW (DATA_AW),
    .W  (RAM_W)
  ) u_data_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (wr_spec[DATA_AW-1:0]),
    .wdata ({rx_axis.tdata, rx_axis.tkeep, rx_axis.tlast}),
    .re    (ram_re),
    .raddr (rd_ptr[DATA_AW-1:0]),
    .rdata (ram_rdata)
  );

  assign {tx_axis.tdata, tx_axis.tkeep, tx_axis.tlast} = ram_rdata;

endmodule

// File: tb/tb_qci_ingress_frame_buffer.sv
// tb_qci_ingress_frame_buffer: directed plus randomized frames against a
// queue-based reference model (accepted frames in order, oversize dropped).
module tb_qci_ingress_frame_buffer;
  import qci_pkg::*;

  localparam int DATA_AW = 9;
  localparam int LEN_AW  = 4;
  localparam int MAX_LEN = 1522;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qci_ingress_frame_buffer_if rx_if ();
  qci_ingress_frame_buffer_if tx_if ();
  logic [FRAME_LEN_W-1:0] frame_len_out;
  logic [15:0]            drop_count_out;

  qci_ingress_frame_buffer #(
    .DATA_AW (DATA_AW),
    .LEN_AW  (LEN_AW),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_axis        (rx_if),
    .tx_axis        (tx_if),
    .frame_len_out  (frame_len_out),
    .drop_count_out (drop_count_out)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: beats {tdata,tkeep,tlast} and lengths of accepted frames.
  logic [72:0] exp_beats[$];
  int          exp_lens[$];
  int          exp_drops = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tlast_cyc = 0;
  int rise_cyc  = -100;
  int last_tlast_cyc = 0;
  bit gap_chk   = 0;
  bit saw_tlast = 0;

  // tx_axis.tready pattern: 0 hold low, 1 hold high, 2 random, 3 1,0,0,1
  int tx_mode = 1;
  initial begin
    int pat = 0;
    tx_if.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (tx_mode)
        0: tx_if.tready = 1'b0;
        1: tx_if.tready = 1'b1;
        2: tx_if.tready = 1'($urandom_range(0, 1));
        default: begin
          tx_if.tready = (pat == 0 || pat == 3);
          pat = (pat + 1) % 4;
        end
      endcase
    end
  end

  // Egress monitor.
  initial begin
    logic [63:0] pd;
    logic [7:0]  pk;
    logic        pl;
    logic [10:0] pfl;
    logic [72:0] b;
    bit prev_stall = 0;
    bit prev_valid = 0;
    bit in_frame   = 0;
    pd = '0; pk = '0; pl = 1'b0; pfl = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
        prev_valid = 0;
        in_frame   = 0;
        continue;
      end
      if (prev_stall) begin
        chk("stall_tvalid", tx_if.tvalid, 1);
        chk("stall_tdata", tx_if.tdata, pd);
        chk("stall_tkeep", tx_if.tkeep, pk);
        chk("stall_tlast", tx_if.tlast, pl);
        chk("stall_len", frame_len_out, pfl);
      end
      if (tx_if.tvalid && !prev_valid) rise_cyc = cyc;
      if (tx_if.tvalid && tx_if.tready) begin
        if (exp_beats.size() == 0) begin
          chk("unexpected_beat", tx_if.tdata, 64'hDEAD_BEEF_DEAD_BEEF);
        end else begin
          b = exp_beats.pop_front();
          if (!in_frame && gap_chk && saw_tlast)
            chk("ifg_le1", 64'(cyc - last_tlast_cyc - 1 <= 1), 1);
          in_frame = 1;
          chk("tdata", tx_if.tdata, b[72:9]);
          chk("tkeep", tx_if.tkeep, b[8:1]);
          chk("tlast", tx_if.tlast, b[0]);
          chk("frame_len", frame_len_out, exp_lens[0]);
          if (b[0]) begin
            void'(exp_lens.pop_front());
            last_tlast_cyc = cyc;
            saw_tlast = 1;
            in_frame  = 0;
          end
        end
      end
      prev_valid = tx_if.tvalid;
      prev_stall = tx_if.tvalid && !tx_if.tready;
      pd = tx_if.tdata; pk = tx_if.tkeep; pl = tx_if.tlast; pfl = frame_len_out;
    end
  end

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    bit ok = 0;
    rx_if.tdata  = d;
    rx_if.tkeep  = k;
    rx_if.tlast  = l;
    rx_if.tvalid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rx_if.tready) begin
        ok = 1;
        if (l) tlast_cyc = cyc;
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    rx_if.tvalid = 1'b0;
    if (!ok) chk("rx_ready_timeout", 0, 1);
  endtask

  task automatic send_frame(input int nbytes, input bit gaps);
    logic [72:0] beats[$];
    logic [63:0] d;
    logic [7:0]  k;
    int nb, rem, take;
    nb  = (nbytes == 0) ? 1 : (nbytes + 7) / 8;
    rem = nbytes;
    for (int i = 0; i < nb; i++) begin
      take = (rem > 8) ? 8 : rem;
      k    = 8'((1 << take) - 1);
      rem  = rem - take;
      d    = {$urandom, $urandom};
      beats.push_back({d, k, (i == nb - 1)});
    end
    foreach (beats[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_beat(beats[i][72:9], beats[i][8:1], beats[i][0]);
    end
    if (nbytes > MAX_LEN) begin
      exp_drops++;
    end else begin
      foreach (beats[i]) exp_beats.push_back(beats[i]);
      exp_lens.push_back(nbytes);
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_beats.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk(tag, exp_beats.size(), 0);
    chk({tag, "_drops"}, drop_count_out, exp_drops);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rx_if.tvalid = 1'b0;
    rx_if.tdata  = '0;
    rx_if.tkeep  = '0;
    rx_if.tlast  = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", tx_if.tvalid, 0);
    chk("rst_tdata", tx_if.tdata, 0);
    chk("rst_tkeep", tx_if.tkeep, 0);
    chk("rst_tlast", tx_if.tlast, 0);
    chk("rst_len", frame_len_out, 0);
    chk("rst_drops", drop_count_out, 0);
    chk("rst_rx_tready", rx_if.tready, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: single 20-byte frame, latency tlast -> tvalid
    tx_mode  = 1;
    rise_cyc = -100;
    send_frame(20, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("t1_latency", rise_cyc - tlast_cyc, 2);
    wait_drain("t1_drain");

    // 2: back-to-back 64 B / 65 B, then both queued and drained for the gap
    send_frame(64, 0);
    send_frame(65, 0);
    wait_drain("t2_drain");
    tx_mode = 0;
    send_frame(64, 0);
    send_frame(65, 0);
    saw_tlast = 0;
    gap_chk   = 1;
    tx_mode   = 1;
    wait_drain("t2_gap_drain");
    gap_chk = 0;

    // 3: oversize drop, then exact MAX_LEN boundary either side
    send_frame(1528, 0);
    send_frame(64, 0);
    wait_drain("t3_drain");
    chk("t3_drop_count", drop_count_out, 1);
    chk("t3_rx_tready", rx_if.tready, 1);
    send_frame(MAX_LEN, 0);
    send_frame(MAX_LEN + 1, 0);
    send_frame(0, 0);
    wait_drain("t3_bound_drain");

    // 4: tready 1,0,0,1 backpressure
    tx_mode = 3;
    for (int i = 0; i < 4; i++) send_frame($urandom_range(1, 200), 1);
    wait_drain("t4_drain");

    // 5: fill the length FIFO with tx stalled
    tx_mode = 0;
    for (int i = 0; i < (1 << LEN_AW); i++) send_frame(64, 0);
    @(negedge clk);
    chk("t5_full_tready", rx_if.tready, 0);
    @(posedge clk);
    #1;
    saw_tlast = 0;
    gap_chk   = 1;
    fork
      begin
        repeat (30) @(posedge clk);
        #1;
        tx_mode = 1;
      end
      send_frame(64, 0);
    join
    wait_drain("t5_drain");
    gap_chk = 0;

    // 6: reset in the middle of a frame with a stalled frame on tx
    tx_mode = 0;
    send_frame(16, 0);
    send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
    send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
    @(negedge clk);
    chk("t6_pre_tvalid", tx_if.tvalid, 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_tvalid", tx_if.tvalid, 0);
    chk("t6_tdata", tx_if.tdata, 0);
    chk("t6_tkeep", tx_if.tkeep, 0);
    chk("t6_len", frame_len_out, 0);
    chk("t6_drops", drop_count_out, 0);
    exp_beats.delete();
    exp_lens.delete();
    exp_drops = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tx_mode = 1;
    @(posedge clk);
    #1;
    send_frame(16, 0);
    wait_drain("t6_drain");

    // 7: randomized mix with random tready and ingress bubbles
    tx_mode = 2;
    for (int i = 0; i < 30; i++) begin
      int r;
      int len;
      r = $urandom_range(0, 9);
      if (r == 0)      len = $urandom_range(MAX_LEN + 1, 1600);
      else if (r == 1) len = $urandom_range(0, 8);
      else             len = $urandom_range(1, 300);
      send_frame(len, 1);
    end
    wait_drain("t7_drain");
    chk("t7_len_queue", exp_lens.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/qci_ingress_frame_buffer.md
Name: qci_ingress_frame_buffer

Overview:
Store-and-forward ingress buffer placed directly upstream of the Qci filtering/policing pipeline. It accepts raw 64-bit AXI-Stream frames, counts bytes per frame from tkeep, and releases a frame only after its last beat has arrived. The released frame carries `frame_len_out`, which is stable for the whole frame and feeds the pipeline's `frame_len_in`. Frames longer than MAX_LEN bytes are dropped by write-pointer rollback and counted.

Parameters:
DATA_AW, 9, data FIFO address width; depth = 2^DATA_AW beats of {tdata, tkeep, tlast}.
LEN_AW, 4, length FIFO address width; depth = 2^LEN_AW committed frames.
MAX_LEN, 1522, largest accepted frame in bytes. Constraint: MAX_LEN ≤ 2047 and 2^DATA_AW ≥ ceil(MAX_LEN/8)+1; an elaboration check fails otherwise.

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
rx_axis_tdata  in  64  ingress data
rx_axis_tkeep  in  8  byte enables, LSB-first contiguous
rx_axis_tlast  in  1  last beat of frame
rx_axis_tvalid  in  1  ingress valid
rx_axis_tready  out  1  ingress ready
tx_axis_tdata  out  64  egress data
tx_axis_tkeep  out  8  egress byte enables
tx_axis_tlast  out  1  egress last beat
tx_axis_tvalid  out  1  egress valid
tx_axis_tready  in  1  egress ready
frame_len_out  out  11  byte length of the frame currently on tx
drop_count_out  out  16  oversize frames dropped, saturating

Behaviour:
- Reset (asynchronous, active-high): every output is 0, all pointers are 0, and both FIFOs are empty. A partial frame is discarded. The first beat accepted after reset is treated as the start of a frame.
- Write side has two states, W_ACCEPT and W_DROP.
- W_ACCEPT:
  - rx_axis_tready = !data_full && !len_full.
  - Each accepted beat is written at the speculative pointer `wr_spec`. The pointer then increments.
  - `byte_cnt` (12-bit) accumulates popcount(tkeep).
- Oversize: if `byte_cnt + popcount(tkeep) > MAX_LEN` on an accepted beat, that beat is not written.
  - `wr_spec` reverts to `wr_commit`.
  - drop_count_out increments, holding at 0xFFFF.
  - If the beat has no tlast, the write side enters W_DROP. If it has tlast, the write side stays in W_ACCEPT with `byte_cnt` = 0.
- W_DROP: rx_axis_tready = 1; beats are discarded. The tlast beat returns the write side to W_ACCEPT with `byte_cnt` = 0.
- Commit: on an accepted in-range tlast beat, in the same clock edge:
  - `wr_commit` ← `wr_spec` + 1;
  - the final `byte_cnt` (11 bits) is pushed to the length FIFO;
  - `byte_cnt` ← 0.
- A single tlast beat with tkeep = 0 commits a frame of length 0; no special case.
- data_full is computed against `rd_ptr`. The read side sees only `wr_commit`, so uncommitted beats are never visible to it.
- Read side has three states:
  - R_IDLE: when the length FIFO is non-empty, pop the length into frame_len_out, issue the RAM read, go to R_LOAD.
  - R_LOAD: output register filled, tx_axis_tvalid = 1, go to R_SEND.
  - R_SEND: on each handshake, advance to the next beat using a prefetch/skid register so streaming runs at 1 beat per cycle. On handshake with tx_axis_tlast = 1, go to R_IDLE, or straight to R_LOAD if another length is already queued.
- Read-side latency: a tlast accepted at cycle N gives tx_axis_tvalid = 1 at N+2 when the read side is idle.
- Inter-frame gap: at most 1 idle cycle between frames.
- Output stability: tdata, tkeep, tlast and frame_len_out hold while tvalid && !tready. frame_len_out is constant from the first beat through the tlast beat.
- Simultaneous events:
  - Commit and read-side pop in the same cycle: the length FIFO count is unchanged.
  - Rollback and read in the same cycle: both take effect; they touch disjoint pointers.
- Pointers are one bit wider than the address, so wrap-around is handled natively.

Decomposition:
- Package `qci_pkg` holds:
  - `localparam FRAME_LEN_W = 11`;
  - a `write_state_t` enum;
  - a `read_state_t` enum;
  - a `popcount8` function.
- One natural sub-module: `qci_sdp_ram`, a simple dual-port RAM with 1-cycle registered read, width 73, used for the data FIFO. The length FIFO is inline registers.

Test Plan:
1. Single frame: 3 beats with tkeep FF, FF, 0F and tlast on beat 3 at cycle N → tx_axis_tvalid rises at N+2; 3 identical beats out; frame_len_out = 20 throughout.
2. Back-to-back frames of 64 B and 65 B, with tx_axis_tready held at 1 → lengths 64 then 65; at most 1 idle cycle between the frames; no beat reordering.
3. Oversize: MAX_LEN = 1522, 191-beat full frame (1528 B), followed by a 64 B frame → only the 64 B frame is emitted with frame_len_out = 64; drop_count_out = 1; the FIFO level returns to its pre-frame value.
4. Backpressure: tx_axis_tready toggling 1,0,0,1 during the frame → outputs stable during stalls; beat sequence identical to the input.
5. Full: 2^LEN_AW + 1 minimum frames sent with tx_axis_tready = 0 → rx_axis_tready drops after the 16th commit; the frames drain intact once tx_axis_tready = 1.
6. Reset mid-frame: assert rst after beat 2 of a 5-beat frame, then send a 2-beat 16 B frame → outputs go to 0 immediately; only the 16 B frame is emitted, with frame_len_out = 16.
